// File: rtl/ddr_cmd_pkg.sv
// Shared types and command-pin encoding for the DDR4 command scheduler.
package ddr_cmd_pkg;

  // Width of the command/address bus the encodings below are defined on (A16..A0)
  localparam int CMD_AW  = 17;
  localparam int RAS_BIT = 16;
  localparam int CAS_BIT = 15;
  localparam int WE_BIT  = 14;
  localparam int AP_BIT  = 10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRE,
    S_WAIT_RP,
    S_ACT,
    S_WAIT_RCD,
    S_CAS,
    S_BURST,
    S_PREA,
    S_WAIT_RP_ALL
  } state_e;

  typedef enum logic [2:0] {
    CMD_DES,
    CMD_ACT,
    CMD_RD,
    CMD_WR,
    CMD_PRE,
    CMD_PREA
  } cmd_e;

  // Build the A bus for a command; row/col arrive zero-extended to CMD_AW bits
  function automatic logic [CMD_AW-1:0] cmd_addr(input cmd_e cmd,
                                                 input logic [CMD_AW-1:0] row,
                                                 input logic [CMD_AW-1:0] col);
    logic [CMD_AW-1:0] a;
    a = '0;
    case (cmd)
      CMD_ACT: a = row;
      CMD_RD, CMD_WR: begin
        a          = col;
        a[RAS_BIT] = 1'b1;
        a[CAS_BIT] = 1'b0;
        a[WE_BIT]  = (cmd == CMD_RD);
        a[AP_BIT]  = 1'b0;
      end
      CMD_PRE, CMD_PREA: begin
        a[RAS_BIT] = 1'b0;
        a[CAS_BIT] = 1'b1;
        a[WE_BIT]  = 1'b0;
        a[AP_BIT]  = (cmd == CMD_PREA);
      end
      default: a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/open_row_table.sv
// Per-bank open-row tracker: a valid bit and row register for every bank,
// with a combinational lookup port and set / clear / clear-all update ports.
module open_row_table #(
  parameter int BANKW = 4,
  parameter int ROWW  = 17
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [BANKW-1:0] lookup_bank,
  output logic             lookup_valid,
  output logic [ROWW-1:0]  lookup_row,
  input  logic             set_en,
  input  logic [BANKW-1:0] set_bank,
  input  logic [ROWW-1:0]  set_row,
  input  logic             clr_en,
  input  logic [BANKW-1:0] clr_bank,
  input  logic             clr_all
);

  localparam int NBANK = 1 << BANKW;

  logic [NBANK-1:0] valid_vec;
  logic [ROWW-1:0]  row_arr [NBANK];

  genvar gi;
  generate
    for (gi = 0; gi < NBANK; gi++) begin : g_bank
      logic            valid_reg;
      logic [ROWW-1:0] row_reg;

      // Closing wins over opening; a bank is only opened by an ACT to it
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          valid_reg <= 1'b0;
          row_reg   <= '0;
        end else if (clr_all || (clr_en && clr_bank == BANKW'(gi))) begin
          valid_reg <= 1'b0;
        end else if (set_en && set_bank == BANKW'(gi)) begin
          valid_reg <= 1'b1;
          row_reg   <= set_row;
        end
      end

      assign valid_vec[gi] = valid_reg;
      assign row_arr[gi]   = row_reg;
    end
  endgenerate

  assign lookup_valid = valid_vec[lookup_bank];
  assign lookup_row   = row_arr[lookup_bank];

endmodule

// File: rtl/ddr_cmd_sched.sv
// DDR4 command scheduler: one request in flight, issues PRE/ACT/RD/WR/PREA
// with tRP, tRCD and CAS-to-data spacing; all command pins are registered.
module ddr_cmd_sched
  import ddr_cmd_pkg::*;
#(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int BL        = 8,
  parameter int TRP       = 4,
  parameter int TRCD      = 4,
  parameter int TCL       = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [BGWIDTH-1:0]   req_bg,
  input  logic [BAWIDTH-1:0]   req_ba,
  input  logic [ADDRWIDTH-1:0] req_row,
  input  logic [COLWIDTH-1:0]  req_col,
  input  logic                 flush,
  output logic                 done,
  output logic                 done_we,
  output logic                 act_n,
  output logic                 cs_n,
  output logic [ADDRWIDTH-1:0] A,
  output logic [BGWIDTH-1:0]   bg,
  output logic [BAWIDTH-1:0]   ba
);

  localparam int BANKW   = BGWIDTH + BAWIDTH;
  localparam int T_BURST = TCL + BL;
  localparam int T_MAX   = (TRP > TRCD) ? ((TRP > T_BURST) ? TRP : T_BURST)
                                        : ((TRCD > T_BURST) ? TRCD : T_BURST);
  localparam int CNTW    = $clog2(T_MAX + 1);

  state_e                 state_reg;
  logic [CNTW-1:0]        cnt_reg;
  logic [BGWIDTH-1:0]     bg_lat_reg;
  logic [BAWIDTH-1:0]     ba_lat_reg;
  logic [ADDRWIDTH-1:0]   row_lat_reg;
  logic [COLWIDTH-1:0]    col_lat_reg;
  logic                   we_lat_reg;
  logic                   ready_reg;
  logic                   done_reg;
  logic                   done_we_reg;
  logic                   cs_n_reg;
  logic                   act_n_reg;
  logic [ADDRWIDTH-1:0]   a_reg;
  logic [BGWIDTH-1:0]     bg_reg;
  logic [BAWIDTH-1:0]     ba_reg;

  logic                   tbl_valid;
  logic [ADDRWIDTH-1:0]   tbl_row;
  logic                   row_hit;

  open_row_table #(
    .BANKW (BANKW),
    .ROWW  (ADDRWIDTH)
  ) u_table (
    .clk          (clk),
    .reset_n      (reset_n),
    .lookup_bank  ({req_bg, req_ba}),
    .lookup_valid (tbl_valid),
    .lookup_row   (tbl_row),
    .set_en       (state_reg == S_ACT),
    .set_bank     ({bg_lat_reg, ba_lat_reg}),
    .set_row      (row_lat_reg),
    .clr_en       (state_reg == S_PRE),
    .clr_bank     ({bg_lat_reg, ba_lat_reg}),
    .clr_all      (state_reg == S_PREA)
  );

  assign row_hit = tbl_valid && (tbl_row == req_row);

  // flush takes the idle slot, so it must also withdraw ready in that cycle
  assign req_ready = ready_reg & ~flush;
  assign done      = done_reg;
  assign done_we   = done_we_reg;
  assign cs_n      = cs_n_reg;
  assign act_n     = act_n_reg;
  assign A         = a_reg;
  assign bg        = bg_reg;
  assign ba        = ba_reg;

  // Scheduler FSM; every command state drives its pins for exactly one cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      bg_lat_reg  <= '0;
      ba_lat_reg  <= '0;
      row_lat_reg <= '0;
      col_lat_reg <= '0;
      we_lat_reg  <= 1'b0;
      ready_reg   <= 1'b0;
      done_reg    <= 1'b0;
      done_we_reg <= 1'b0;
      cs_n_reg    <= 1'b1;
      act_n_reg   <= 1'b1;
      a_reg       <= '0;
      bg_reg      <= '0;
      ba_reg      <= '0;
    end else begin
      cs_n_reg    <= 1'b1;
      act_n_reg   <= 1'b1;
      a_reg       <= '0;
      bg_reg      <= '0;
      ba_reg      <= '0;
      done_reg    <= 1'b0;
      done_we_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (flush) begin
            ready_reg <= 1'b0;
            state_reg <= S_PREA;
          end else if (req_valid && ready_reg) begin
            ready_reg   <= 1'b0;
            bg_lat_reg  <= req_bg;
            ba_lat_reg  <= req_ba;
            row_lat_reg <= req_row;
            col_lat_reg <= req_col;
            we_lat_reg  <= req_we;
            if (row_hit)        state_reg <= S_CAS;
            else if (tbl_valid) state_reg <= S_PRE;
            else                state_reg <= S_ACT;
          end else begin
            ready_reg <= 1'b1;
          end
        end
        S_PRE: begin
          cs_n_reg <= 1'b0;
          a_reg    <= ADDRWIDTH'(cmd_addr(CMD_PRE, '0, '0));
          bg_reg   <= bg_lat_reg;
          ba_reg   <= ba_lat_reg;
          cnt_reg  <= CNTW'(TRP - 1);
          state_reg <= (TRP > 1) ? S_WAIT_RP : S_ACT;
        end
        S_WAIT_RP: begin
          if (cnt_reg <= CNTW'(1)) state_reg <= S_ACT;
          else                     cnt_reg   <= cnt_reg - CNTW'(1);
        end
        S_ACT: begin
          cs_n_reg  <= 1'b0;
          act_n_reg <= 1'b0;
          a_reg     <= ADDRWIDTH'(cmd_addr(CMD_ACT, CMD_AW'(row_lat_reg), '0));
          bg_reg    <= bg_lat_reg;
          ba_reg    <= ba_lat_reg;
          cnt_reg   <= CNTW'(TRCD - 1);
          state_reg <= (TRCD > 1) ? S_WAIT_RCD : S_CAS;
        end
        S_WAIT_RCD: begin
          if (cnt_reg <= CNTW'(1)) state_reg <= S_CAS;
          else                     cnt_reg   <= cnt_reg - CNTW'(1);
        end
        S_CAS: begin
          cs_n_reg  <= 1'b0;
          a_reg     <= ADDRWIDTH'(cmd_addr(we_lat_reg ? CMD_WR : CMD_RD, '0,
                                           CMD_AW'(col_lat_reg)));
          bg_reg    <= bg_lat_reg;
          ba_reg    <= ba_lat_reg;
          // Burst spans CAS latency plus the data beats; done follows the last beat
          cnt_reg   <= CNTW'(T_BURST);
          state_reg <= S_BURST;
        end
        S_BURST: begin
          if (cnt_reg <= CNTW'(1)) begin
            done_reg    <= 1'b1;
            done_we_reg <= we_lat_reg;
            ready_reg   <= 1'b1;
            state_reg   <= S_IDLE;
          end else begin
            cnt_reg <= cnt_reg - CNTW'(1);
          end
        end
        S_PREA: begin
          cs_n_reg <= 1'b0;
          a_reg    <= ADDRWIDTH'(cmd_addr(CMD_PREA, '0, '0));
          cnt_reg  <= CNTW'(TRP - 1);
          if (TRP > 1) begin
            state_reg <= S_WAIT_RP_ALL;
          end else begin
            ready_reg <= 1'b1;
            state_reg <= S_IDLE;
          end
        end
        S_WAIT_RP_ALL: begin
          if (cnt_reg <= CNTW'(1)) begin
            ready_reg <= 1'b1;
            state_reg <= S_IDLE;
          end else begin
            cnt_reg <= cnt_reg - CNTW'(1);
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_cmd_sched.sv
// Randomised scoreboard bench for ddr_cmd_sched: the driver predicts every
// command and done pulse (with its cycle) from the open-row rules, and an
// independent monitor checks what appears on the pins against that queue.
module tb_ddr_cmd_sched;

  localparam int TRP  = 4;
  localparam int TRCD = 4;
  localparam int TCL  = 5;
  localparam int BL   = 8;

  localparam logic [16:0] ENC_RD   = 17'h14000;
  localparam logic [16:0] ENC_WR   = 17'h10000;
  localparam logic [16:0] ENC_PRE  = 17'h08000;
  localparam logic [16:0] ENC_PREA = 17'h08400;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_bg;
  logic [1:0]  req_ba;
  logic [16:0] req_row;
  logic [9:0]  req_col;
  logic        flush;
  logic        done;
  logic        done_we;
  logic        act_n;
  logic        cs_n;
  logic [16:0] A;
  logic [1:0]  bg;
  logic [1:0]  ba;

  ddr_cmd_sched #(
    .BGWIDTH(2), .BAWIDTH(2), .ADDRWIDTH(17), .COLWIDTH(10),
    .BL(BL), .TRP(TRP), .TRCD(TRCD), .TCL(TCL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
    .req_col(req_col), .flush(flush), .done(done), .done_we(done_we),
    .act_n(act_n), .cs_n(cs_n), .A(A), .bg(bg), .ba(ba)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int          cyc;
    bit          is_done;
    bit          act_n;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [16:0] a;
    bit          we;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model: which row each bank holds open
  bit          open_v   [16];
  logic [16:0] open_row [16];

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) open_v[i] = 1'b0;
  endfunction

  function automatic void push_ev(int c, bit d, bit an, logic [1:0] g, logic [1:0] b,
                                  logic [16:0] a, bit we);
    exp_t e;
    e.cyc = c; e.is_done = d; e.act_n = an; e.bg = g; e.ba = b; e.a = a; e.we = we;
    exp_q.push_back(e);
  endfunction

  // Predict the command sequence of a request accepted at edge t0
  function automatic void push_req(int t0, bit we, logic [1:0] g, logic [1:0] b,
                                   logic [16:0] row, logic [9:0] col);
    int t;
    int k;
    logic [16:0] cas_a;
    k = int'({g, b});
    t = t0 + 1;
    if (!(open_v[k] && open_row[k] == row)) begin
      if (open_v[k]) begin
        push_ev(t, 1'b0, 1'b1, g, b, ENC_PRE, 1'b0);
        t += TRP;
      end
      push_ev(t, 1'b0, 1'b0, g, b, row, 1'b0);
      t += TRCD;
      open_v[k]   = 1'b1;
      open_row[k] = row;
    end
    cas_a = (we ? ENC_WR : ENC_RD) | {7'd0, col};
    push_ev(t, 1'b0, 1'b1, g, b, cas_a, 1'b0);
    push_ev(t + TCL + BL, 1'b1, 1'b1, 2'd0, 2'd0, 17'd0, we);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Monitor: pops expected events whenever the DUT shows a command or done
  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_cmp++; n_err++;
        $display("FAIL missing_event cyc=%0d expected_at=%0d done=%0b A=%h",
                 cyc, exp_q[0].cyc, exp_q[0].is_done, exp_q[0].a);
        exp_q.delete(0);
      end
      n_cmp++;
      if (cs_n === 1'b0) begin
        if (exp_q.size() == 0 || exp_q[0].is_done) begin
          n_err++;
          $display("FAIL unexpected_cmd cyc=%0d act_n=%b bg=%0d ba=%0d A=%h", cyc, act_n, bg, ba, A);
        end else begin
          mon_e = exp_q[0];
          exp_q.delete(0);
          if (mon_e.cyc != cyc || mon_e.act_n !== act_n || mon_e.bg !== bg ||
              mon_e.ba !== ba || mon_e.a !== A) begin
            n_err++;
            $display("FAIL cmd cyc=%0d act_n=%b bg=%0d ba=%0d A=%h required cyc=%0d act_n=%b bg=%0d ba=%0d A=%h",
                     cyc, act_n, bg, ba, A, mon_e.cyc, mon_e.act_n, mon_e.bg, mon_e.ba, mon_e.a);
          end
        end
      end else if (act_n !== 1'b1 || A !== 17'd0) begin
        n_err++;
        $display("FAIL deselect cyc=%0d cs_n=%b act_n=%b A=%h required act_n=1 A=0", cyc, cs_n, act_n, A);
      end
      if (done !== 1'b0) begin
        n_cmp++;
        if (exp_q.size() == 0 || !exp_q[0].is_done) begin
          n_err++;
          $display("FAIL unexpected_done cyc=%0d done=%b done_we=%b", cyc, done, done_we);
        end else begin
          mon_e = exp_q[0];
          exp_q.delete(0);
          if (mon_e.cyc != cyc || mon_e.we !== done_we || done !== 1'b1) begin
            n_err++;
            $display("FAIL done cyc=%0d done_we=%b required cyc=%0d done_we=%b",
                     cyc, done_we, mon_e.cyc, mon_e.we);
          end else begin
            $display("DONE cyc=%0d we=%0b", cyc, done_we);
          end
        end
      end
    end
  end

  // Present a request (called just after a negedge); returns one negedge after acceptance
  task automatic send(input bit we, input logic [1:0] g, input logic [1:0] b,
                      input logic [16:0] row, input logic [9:0] col, input bit keep);
    int n;
    int t0;
    n = 0;
    req_valid = 1'b1; req_we = we; req_bg = g; req_ba = b; req_row = row; req_col = col;
    #1;
    while (req_ready !== 1'b1 && n < 500) begin
      @(negedge clk); #1; n++;
    end
    if (req_ready !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout cyc=%0d req_ready=%b required 1", cyc, req_ready);
      req_valid = 1'b0;
      return;
    end
    t0 = cyc + 1;
    push_req(t0, we, g, b, row, col);
    $display("REQ  cyc=%0d we=%0b bg=%0d ba=%0d row=%h col=%h", t0, we, g, b, row, col);
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
  endtask

  // Wait until nothing is outstanding and the scheduler is back in IDLE
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk); #1;
    while ((exp_q.size() != 0 || req_ready !== 1'b1) && n < 1000) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 1000) begin
      n_cmp++; n_err++;
      $display("FAIL idle_timeout cyc=%0d pending=%0d req_ready=%b", cyc, exp_q.size(), req_ready);
    end
  endtask

  // Precharge-all from IDLE, optionally with a competing request held valid
  task automatic do_flush(input bit with_req, input logic [1:0] g, input logic [1:0] b,
                          input logic [16:0] row);
    int low;
    int n;
    low = 0; n = 0;
    flush = 1'b1; req_valid = with_req; req_bg = g; req_ba = b; req_row = row;
    req_we = 1'b0; req_col = 10'd0;
    #1;
    if (req_ready !== 1'b1) low++;
    push_ev(cyc + 2, 1'b0, 1'b1, 2'd0, 2'd0, ENC_PREA, 1'b0);
    model_clear();
    $display("FLSH cyc=%0d with_req=%0b", cyc + 1, with_req);
    @(negedge clk);
    flush = 1'b0;
    if (with_req) begin
      #1;
      while (req_ready !== 1'b1 && n < 100) begin
        low++; n++;
        @(negedge clk); #1;
      end
      chk("flush_ready_low_cycles", low, TRP + 1);
    end
  endtask

  logic [16:0] rows [3];

  initial begin
    int t0;
    bit keep;
    bit prev_keep;
    logic [1:0] g;
    logic [1:0] b;

    rows[0] = 17'h00010; rows[1] = 17'h00020; rows[2] = 17'h1FFFF;
    reset_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_bg = '0; req_ba = '0; req_row = '0; req_col = '0;
    model_clear();

    repeat (3) @(negedge clk);
    #1;
    chk("reset_cs_n", cs_n, 1);
    chk("reset_act_n", act_n, 1);
    chk("reset_A", A, 0);
    chk("reset_bg", bg, 0);
    chk("reset_ba", ba, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_done", done, 0);
    chk("reset_done_we", done_we, 0);
    reset_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    #1;
    chk("ready_after_reset", req_ready, 1);

    // Closed bank read, row-hit write, row-miss write
    send(1'b0, 2'd1, 2'd2, 17'h00155, 10'h03A, 1'b0);
    wait_idle();
    send(1'b1, 2'd1, 2'd2, 17'h00155, 10'h03A, 1'b0);
    wait_idle();
    send(1'b1, 2'd1, 2'd2, 17'h000AA, 10'h03A, 1'b0);
    wait_idle();

    // flush beats a same-cycle request; the request then sees a closed bank
    do_flush(1'b1, 2'd1, 2'd2, 17'h000AA);
    send(1'b0, 2'd1, 2'd2, 17'h000AA, 10'h011, 1'b0);
    wait_idle();

    // Reset while waiting tRCD: no CAS, no done, table forgotten
    send(1'b0, 2'd2, 2'd1, 17'h00033, 10'h005, 1'b0);
    t0 = cyc;
    @(negedge clk);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    #1;
    chk("midop_reset_cyc", cyc - t0, 3);
    chk("midop_cs_n", cs_n, 1);
    chk("midop_act_n", act_n, 1);
    chk("midop_A", A, 0);
    chk("midop_req_ready", req_ready, 0);
    chk("midop_done", done, 0);
    chk("midop_done_we", done_we, 0);
    reset_n = 1'b1;
    model_clear();
    @(negedge clk);
    #1;
    chk("midop_ready_after_reset", req_ready, 1);
    send(1'b0, 2'd2, 2'd1, 17'h00033, 10'h005, 1'b0);
    wait_idle();

    // Back-to-back with req_valid held high throughout
    send(1'b0, 2'd0, 2'd0, 17'h00010, 10'h001, 1'b1);
    send(1'b1, 2'd0, 2'd0, 17'h00010, 10'h002, 1'b1);
    send(1'b0, 2'd0, 2'd1, 17'h00020, 10'h003, 1'b1);
    send(1'b1, 2'd0, 2'd0, 17'h00020, 10'h004, 1'b0);
    wait_idle();

    // Randomised traffic
    prev_keep = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!prev_keep && $urandom_range(0, 9) == 0) begin
        wait_idle();
        do_flush(1'b0, 2'd0, 2'd0, 17'd0);
      end
      g = 2'($urandom_range(0, 3));
      b = 2'($urandom_range(0, 1));
      keep = ($urandom_range(0, 2) == 0);
      send(1'($urandom_range(0, 1)), g, b, rows[$urandom_range(0, 2)],
           10'($urandom_range(0, 1023)), keep);
      if (!keep) begin
        if ($urandom_range(0, 3) == 0) begin
          flush = 1'b1;
          @(negedge clk);
          flush = 1'b0;
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      prev_keep = keep;
    end
    req_valid = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d pending=%0d", cyc, exp_q.size());
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ddr_cmd_sched.md
# ddr_cmd_sched

DDR4 command scheduler for the DRAM emulation path. It accepts one memory request at a time on a valid/ready interface. It tracks the open row of every bank and generates the legal ACT / PRE / RD / WR sequence on the `dimm` command pins (`act_n`, `A`, `bg`, `ba`, `cs_n`), honouring tRP, tRCD and CAS-to-data timing. It sits between the host-side request source (testbench or AXI front end) and `dimm`, replacing hand-written command stimulus.

## Interface
- BGWIDTH, 2, bank-group address width
- BAWIDTH, 2, bank address width
- ADDRWIDTH, 17, row/command address width (A16..A0)
- COLWIDTH, 10, column width, driven on A[COLWIDTH-1:0]
- BL, 8, burst length in clk cycles of data
- TRP, 4, PRE-to-ACT cycles; TRCD, 4, ACT-to-CAS cycles; TCL, 5, CAS-to-first-data cycles (all ≥1)
- clk  in  1  clock; single clock domain, all logic on posedge
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  scheduler can accept a request
- req_we  in  1  1 = write, 0 = read
- req_bg / req_ba / req_row / req_col  in  BGWIDTH / BAWIDTH / ADDRWIDTH / COLWIDTH  target address
- flush  in  1  close all banks (precharge-all) when idle
- done  out  1  one-cycle pulse: burst of the accepted request completed
- done_we  out  1  req_we of the completed request, valid with done
- act_n, cs_n  out  1 each  DDR4 command pins (single rank)
- A  out  ADDRWIDTH  row address or command bits (A16=ras_n, A15=cas_n, A14=we_n)
- bg / ba  out  BGWIDTH / BAWIDTH  bank-group/bank of the current command

## Operation
- Command encoding, each held for exactly one cycle, otherwise deselect (cs_n=1, act_n=1, A=0):
  - ACT: cs_n=0, act_n=0, A=row
  - RD: cs_n=0, act_n=1, A16=1, A15=0, A14=1, A10=0, A[COLWIDTH-1:0]=col
  - WR: as RD with A14=0
  - PRE: act_n=1, A16=0, A15=1, A14=0, A10=0
  - PREA: as PRE with A10=1
- Open-row table: per bank, a valid bit plus a row register; cleared on reset.
- Handshake: a request is accepted on the cycle `req_valid && req_ready`. Address and we are latched at acceptance.
- FSM states:
  - IDLE: req_ready=1. flush has priority over a same-cycle req_valid; with flush, req_ready=0 and the next state is PREA. On an accepted request:
    - row hit (valid and row equal) → CAS
    - bank closed → ACT
    - other row open → PRE
  - PRE: issue PRE to the latched bank and clear its valid bit → WAIT_RP.
  - WAIT_RP: count TRP−1 cycles → ACT.
  - ACT: issue ACT and set the table entry → WAIT_RCD.
  - WAIT_RCD: count TRCD−1 cycles → CAS.
  - CAS: issue RD or WR → BURST.
  - BURST: count TCL+BL−1 cycles, pulse done on the last cycle → IDLE.
  - PREA: issue PREA, clear all valid bits → WAIT_RP_ALL.
  - WAIT_RP_ALL: count TRP−1 cycles → IDLE.
- Only one request is in flight; requests are never reordered.
- A single down-counter is shared across the wait states. It is sized with $clog2 of max(TRP, TRCD, TCL+BL)+1.

## Timing
- Reset (reset_n=0 at a posedge) forces, on the next cycle:
  - cs_n=1, act_n=1, A=0, bg=0, ba=0
  - req_ready=0, done=0, done_we=0
  - state=IDLE, all table valid bits=0
- req_ready is 1 from the first cycle after reset deasserts.
- Reset mid-operation aborts the request; no done pulse follows. Rows the DRAM considers open are ignored; the host must reset the dimm alongside.
- All outputs are registered. The command appears the cycle after the state is entered.
- Latency from acceptance to the done pulse:
  - row hit: 1+TCL+BL
  - closed bank: 1+TRCD+TCL+BL
  - row miss: 1+TRP+TRCD+TCL+BL
- Exactly one non-deselect command is issued per command state. Consecutive ACT→CAS spacing is exactly TRCD; PRE→ACT spacing is exactly TRP.
- flush in a non-IDLE state is ignored (level-sampled only in IDLE).

## Structure
- Package `ddr_cmd_pkg`:
  - FSM state enum
  - command-bit localparams (RAS/CAS/WE bit indices 16/15/14, AP bit 10)
  - a function building A for each command type
- Sub-module `open_row_table`: per-bank valid/row storage with lookup, set, clear and clear-all ports.

## Test plan
- Reset then read bg=1, ba=2, row=0x155, col=0x3A on a closed bank:
  - ACT A=0x155 one cycle after acceptance
  - RD with A[9:0]=0x3A exactly TRCD later
  - done after 1+4+5+8=18 cycles, done_we=0
- Repeat to the same bank/row as a write: no ACT. WR is the first command; done after 14 cycles, done_we=1.
- Same bank, row=0x0AA:
  - PRE, ACT 0x0AA after TRP, WR after TRCD
  - done after 22 cycles
- flush and req_valid both high in IDLE:
  - PREA (A10=1) issued, req_ready=0 for TRP+1 cycles
  - next request to a previously open row issues ACT
- Assert reset_n=0 during WAIT_RCD:
  - next cycle all outputs at their reset values, no done
  - a following request to the same bank issues ACT, not a hit
- Back-to-back requests with req_valid held high: each accepted only in IDLE, never two in flight, commands never overlap.
